lif_rate_encoder: RTL and testbench

- Source side of the LIF spike interface. Converts a digital intensity word into a rate-coded spike train on `syn`, which drives a neuron's `syn` input.
- Each accepted intensity produces exactly `intensity` single-cycle spikes, evenly spread over a fixed window of 2^WIDTH cycles. The spread uses a phase accumulator.
- Upstream control uses a valid/ready handshake. A `done` strobe marks the end of each window.

---
 rtl/lif_rate_encoder_if.sv | 22 ++
 rtl/lif_rate_encoder.sv | 115 +++++++++++
 tb/tb_lif_rate_encoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lif_rate_encoder_if.sv
// Handshake and spike-output bundle between an upstream controller and lif_rate_encoder.
interface lif_rate_encoder_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_intensity;
  logic             in_ready;
  logic             stop;
  logic             syn;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_intensity, stop,
    input  in_ready, syn, busy, done
  );

  modport slave (
    input  in_valid, in_intensity, stop,
    output in_ready, syn, busy, done
  );
endinterface

// File: rtl/lif_rate_encoder.sv
// Rate encoder: emits exactly I evenly spread spikes per 2^WIDTH-cycle window via a phase accumulator.
// Optional macro LIF_RATE_ENCODER_DITHER_EN seeds each window's accumulator from a 16-bit LFSR.
//
// state | meaning
// IDLE  | waiting for an intensity word, in_ready high
// RUN   | window in progress, one accumulator step per cycle
// DONE  | window finished, done high for one cycle
module lif_rate_encoder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  lif_rate_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] intensity;
  logic             syn_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_init;
  logic             accept;
  logic             last;

  assign sum  = {1'b0, acc} + {1'b0, intensity};
  // cnt is a down-counter loaded with 2^WIDTH-1; reaching zero marks the final RUN edge.
  assign last = (cnt == '0);

`ifdef LIF_RATE_ENCODER_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Taps 16,14,13,11 in right-shifting Fibonacci form.
  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign acc_init = lfsr[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end
`else
  assign acc_init = '0;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      syn_q     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      intensity <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          syn_q <= 1'b0;
          if (accept) begin
            intensity <= bus.in_intensity;
            acc       <= acc_init;
            cnt       <= '1;
          end
        end
        RUN: begin
          if (bus.stop) begin
            syn_q <= 1'b0;
          end else begin
            acc   <= sum[WIDTH-1:0];
            syn_q <= sum[WIDTH];
            cnt   <= cnt - 1'b1;
          end
        end
        default: syn_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.syn      = syn_q;

endmodule

// File: tb/tb_lif_rate_encoder.sv
// Bench for lif_rate_encoder: directed and random windows against an arithmetic spike-position model.
module tb_lif_rate_encoder;
  localparam int WIDTH = 8;
  localparam int N     = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lif_rate_encoder_if #(.WIDTH(WIDTH)) bus ();

  lif_rate_encoder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef LIF_RATE_ENCODER_DITHER_EN
  logic [15:0] model_lfsr = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
`ifdef LIF_RATE_ENCODER_DITHER_EN
    model_lfsr = 16'hACE1;
`endif
  endtask

  // Drives one word through the accepting edge; returns the accumulator start phase.
  task automatic accept_word(input int i_val, input bit keep, input bit with_stop, output int a0);
    chk("ready_before_accept", {31'd0, bus.in_ready}, 1);
`ifdef LIF_RATE_ENCODER_DITHER_EN
    a0 = int'(model_lfsr[WIDTH-1:0]);
    model_lfsr = lfsr_step(model_lfsr);
`else
    a0 = 0;
`endif
    bus.in_valid     = 1'b1;
    bus.in_intensity = i_val[WIDTH-1:0];
    bus.stop         = with_stop;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    if (!keep) bus.in_valid = 1'b0;
    chk("accept_busy", {31'd0, bus.busy}, 1);
    chk("accept_ready", {31'd0, bus.in_ready}, 0);
    chk("accept_syn", {31'd0, bus.syn}, 0);
    chk("accept_done", {31'd0, bus.done}, 0);
  endtask

  // kind: 0 normal, 1 stop before edge abort_at, 2 async rst after edge abort_at, 3 stop during DONE
  task automatic run_window(input int i_val, input int a0, input int abort_at, input int kind);
    int pulses;
    int exp_syn;
    pulses = 0;
    for (int k = 1; k <= N; k++) begin
      if (kind == 1 && k == abort_at) bus.stop = 1'b1;
      @(posedge clk);
      #1;
      bus.stop = 1'b0;
      if (kind == 1 && k == abort_at) begin
        chk("stop_syn", {31'd0, bus.syn}, 0);
        chk("stop_busy", {31'd0, bus.busy}, 0);
        chk("stop_done", {31'd0, bus.done}, 0);
        chk("stop_ready", {31'd0, bus.in_ready}, 1);
        return;
      end
      exp_syn = (((a0 + k * i_val) / N) != ((a0 + (k - 1) * i_val) / N)) ? 1 : 0;
      chk("syn", {31'd0, bus.syn}, exp_syn);
      chk("done_in_window", {31'd0, bus.done}, (k == N) ? 1 : 0);
      chk("busy_in_window", {31'd0, bus.busy}, 1);
      pulses += int'(bus.syn);
      if (kind == 2 && k == abort_at) begin
        #3 rst = 1'b1;
        #1;
        chk("rst_syn", {31'd0, bus.syn}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_ready", {31'd0, bus.in_ready}, 1);
        model_reset();
        #1 rst = 1'b0;
        return;
      end
    end
    chk("pulse_count", pulses, i_val);
    if (kind == 3) bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    chk("end_done", {31'd0, bus.done}, 0);
    chk("end_ready", {31'd0, bus.in_ready}, 1);
    chk("end_busy", {31'd0, bus.busy}, 0);
    chk("end_syn", {31'd0, bus.syn}, 0);
  endtask

  initial begin
    int a0;
    int iv;
    int kind;
    int at;
    bus.in_valid     = 1'b0;
    bus.in_intensity = '0;
    bus.stop         = 1'b0;

    #12;
    chk("reset_ready", {31'd0, bus.in_ready}, 1);
    chk("reset_busy", {31'd0, bus.busy}, 0);
    chk("reset_done", {31'd0, bus.done}, 0);
    chk("reset_syn", {31'd0, bus.syn}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

`ifdef LIF_RATE_ENCODER_DITHER_EN
    accept_word(37, 0, 0, a0);
    chk("dither_first_phase", a0, 32'hE1);
    run_window(37, a0, 0, 0);
    accept_word(37, 0, 0, a0);
    run_window(37, a0, 0, 0);
`endif

    accept_word(128, 0, 0, a0);
    run_window(128, a0, 0, 0);

    accept_word(0, 0, 0, a0);
    run_window(0, a0, 0, 0);
    accept_word(255, 0, 0, a0);
    run_window(255, a0, 0, 3);

    // in_valid stays high; the changed intensity must not leak into the running window
    accept_word(10, 1, 0, a0);
    bus.in_intensity = 8'd20;
    run_window(10, a0, 0, 0);
    accept_word(20, 0, 0, a0);
    run_window(20, a0, 0, 0);

    accept_word(200, 0, 0, a0);
    run_window(200, a0, 100, 1);
    accept_word(77, 0, 0, a0);
    run_window(77, a0, 0, 0);

    accept_word(200, 0, 0, a0);
    run_window(200, a0, 50, 2);
    @(negedge clk);
    accept_word(5, 0, 1, a0);
    run_window(5, a0, 0, 0);

    for (int w = 0; w < 6; w++) begin
      iv   = int'($urandom_range(0, N - 1));
      kind = int'($urandom_range(0, 3));
      at   = int'($urandom_range(1, N));
      if (kind == 2) kind = 0;
      accept_word(iv, 0, 0, a0);
      run_window(iv, a0, at, kind);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
